spi_master_byte: RTL and testbench

SPI mode-0 master byte engine that sits directly upstream of the byte demultiplexer. It serialises one 8-bit tx byte onto MOSI and deserialises 8 MISO bits into rx_data. It presents the received byte together with a registered destination select that drives the demux select input. One transfer per start pulse, MSB first, single chip select.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_master_byte_if.sv | 23 ++
 rtl/spi_sclk_div.sv | 17 +
 rtl/spi_master_byte.sv | 78 +++++++
 tb/tb_spi_master_byte.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master byte engine.
package spi_pkg;
  localparam int DATA_W = 8;
  localparam logic DEST_B = 1'b0;
  localparam logic DEST_C = 1'b1;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
endpackage

// File: rtl/spi_master_byte_if.sv
// spi_master_byte_if: host handshake, received-byte output and SPI pins of the byte engine.
interface spi_master_byte_if;
  import spi_pkg::*;
  logic start;
  logic [DATA_W-1:0] tx_data;
  logic dest_in;
  logic miso;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic busy;
  logic done;
  logic [DATA_W-1:0] rx_data;
  logic dest_sel;
  modport master (
    input start, tx_data, dest_in, miso,
    output sclk, mosi, cs_n, busy, done, rx_data, dest_sel
  );
  modport slave (
    output start, tx_data, dest_in, miso,
    input sclk, mosi, cs_n, busy, done, rx_data, dest_sel
  );
endinterface

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: one-cycle tick every CLK_DIV enabled cycles, restartable by clr.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV + 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/spi_master_byte.sv
// spi_master_byte: SPI mode-0 master moving one byte per start, with registered demux select.
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic clk,
  input logic rst,
  spi_master_byte_if.master bus
);
  localparam int BW = $clog2(DATA_W);
  state_t state, state_n;
  logic tick;
  logic accept;
  logic last_bit;
  logic dest_q;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [BW-1:0] bit_cnt;
  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .clr (state == IDLE),
    .tick(tick)
  );
  assign accept = state == IDLE && bus.start;
  assign last_bit = bit_cnt == BW'(DATA_W - 1);
  assign bus.busy = state != IDLE;
  assign bus.cs_n = state == IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? SETUP : IDLE;
      SETUP:   state_n = tick ? SHIFT : SETUP;
      SHIFT:   state_n = (tick && bus.sclk && last_bit) ? HOLD : SHIFT;
      HOLD:    state_n = tick ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  // sclk rising samples miso; sclk falling advances mosi, so the slave sees a half period of setup
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.sclk <= 1'b0;
      bus.mosi <= 1'b0;
      bus.done <= 1'b0;
      bus.rx_data <= '0;
      bus.dest_sel <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
      bit_cnt <= '0;
      dest_q <= 1'b0;
    end else begin
      bus.done <= state == HOLD && tick;
      if (accept) begin
        tx_sr <= bus.tx_data;
        dest_q <= bus.dest_in;
        bus.mosi <= bus.tx_data[DATA_W-1];
        bit_cnt <= '0;
      end else if (state == SHIFT && tick) begin
        bus.sclk <= ~bus.sclk;
        if (!bus.sclk) rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
        else begin
          bit_cnt <= bit_cnt + 1'b1;
          if (!last_bit) begin
            tx_sr <= tx_sr << 1;
            bus.mosi <= tx_sr[DATA_W-2];
          end
        end
      end else if (state == HOLD && tick) begin
        bus.mosi <= 1'b0;
        bus.rx_data <= rx_sr;
        bus.dest_sel <= dest_q;
      end
    end
endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte: three engines (CLK_DIV 1, 2, 4) driven by vector tables, random transfers and corner sequences.
module tb_spi_master_byte;
  import spi_pkg::*;
  typedef struct {
    int k;
    logic [7:0] tx;
    logic dest;
    logic [7:0] slv;
    logic lp;
    logic [7:0] erx;
    logic edst;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] st, de, lb;
  logic [7:0] tx[3];
  logic [7:0] sb[3];
  logic [2:0] sc, mo, cs, bz, dn, ds;
  logic [7:0] rx[3];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  spi_master_byte_if bus[3] ();
  for (genvar g = 0; g < 3; g++) begin : gen
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [3:0] nf;
    spi_master_byte #(.CLK_DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus[g]));
    assign bus[g].start = st[g];
    assign bus[g].tx_data = tx[g];
    assign bus[g].dest_in = de[g];
    // slave presents bit 7-nf, where nf counts sclk falls since cs_n went low
    assign bus[g].miso = lb[g] ? bus[g].mosi : sb[g][3'(7 - nf)];
    always @(negedge bus[g].sclk or posedge bus[g].cs_n) nf <= bus[g].cs_n ? 4'd0 : nf + 4'd1;
    assign sc[g] = bus[g].sclk;
    assign mo[g] = bus[g].mosi;
    assign cs[g] = bus[g].cs_n;
    assign bz[g] = bus[g].busy;
    assign dn[g] = bus[g].done;
    assign ds[g] = bus[g].dest_sel;
    assign rx[g] = bus[g].rx_data;
  end
  function automatic int dv(input int k);
    return k == 0 ? 1 : k == 1 ? 2 : 4;
  endfunction
  function automatic logic [7:0] model_rx(input logic lp, input logic [7:0] txb, input logic [7:0] slv);
    return lp ? txb : slv;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input int k, input logic [7:0] txb, input logic dest, input logic [7:0] slv,
                     input logic lp, input logic [7:0] erx, input logic edst,
                     input int poke, input logic hold, input logic [7:0] ntx);
    int n, rises;
    logic [7:0] mb, rx0;
    logic ps, got, busok, rxok;
    st[k] = 1'b1; tx[k] = txb; de[k] = dest; sb[k] = slv; lb[k] = lp;
    rx0 = rx[k];
    @(posedge clk); #1;
    st[k] = hold; tx[k] = ntx; de[k] = ~dest;
    chk("accept_busy", bz[k], 1);
    chk("accept_cs_n", cs[k], 0);
    chk("first_mosi", mo[k], txb[7]);
    n = 0; rises = 0; mb = 0; ps = 0; got = 0; busok = 1; rxok = 1;
    while (!got && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (n == poke) begin st[k] = 1'b1; tx[k] = 8'h00; end
      if (n == poke + 1) st[k] = hold;
      if (sc[k] && !ps) begin rises++; mb = {mb[6:0], mo[k]}; end
      ps = sc[k];
      if (dn[k]) got = 1;
      else begin
        if (cs[k] !== 1'b0 || bz[k] !== 1'b1) busok = 0;
        if (rx[k] !== rx0) rxok = 0;
      end
    end
    chk("done_seen", got, 1);
    chk("latency", n, 18 * dv(k));
    chk("sclk_rises", rises, 8);
    chk("mosi_bits", mb, txb);
    chk("cs_busy_during", busok, 1);
    chk("rx_stable", rxok, 1);
    chk("rx_data", rx[k], erx);
    chk("dest_sel", ds[k], edst);
    chk("done_cs_n", cs[k], 1);
    chk("done_busy", bz[k], 0);
    chk("done_sclk", sc[k], 0);
    chk("done_mosi", mo[k], 0);
    if (!hold) begin
      @(posedge clk); #1;
      chk("done_single", dn[k], 0);
      chk("no_requeue", bz[k], 0);
      chk("idle_sclk", sc[k], 0);
    end
  endtask
  vec_t vt[5];
  initial begin
    int n, rises;
    logic ps, quiet;
    logic [7:0] t, s;
    logic d, l;
    int k;
    rst = 1'b1; st = 0; de = 0; lb = 0;
    for (int i = 0; i < 3; i++) begin tx[i] = 0; sb[i] = 0; end
    vt[0] = '{1, 8'hA5, DEST_C, 8'h00, 1'b1, 8'hA5, DEST_C};
    vt[1] = '{2, 8'hFF, DEST_B, 8'h3C, 1'b0, 8'h3C, DEST_B};
    vt[2] = '{0, 8'h01, DEST_B, 8'h00, 1'b1, 8'h01, DEST_B};
    vt[3] = '{2, 8'h00, DEST_C, 8'hFF, 1'b0, 8'hFF, DEST_C};
    vt[4] = '{0, 8'h96, DEST_C, 8'h69, 1'b0, 8'h69, DEST_C};
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk("reset_state", {cs[i], sc[i], mo[i], bz[i], dn[i], rx[i], ds[i]}, {5'b10000, 8'h00, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++)
      run(vt[i].k, vt[i].tx, vt[i].dest, vt[i].slv, vt[i].lp, vt[i].erx, vt[i].edst, 0, 1'b0, 8'h5C);
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(0, 2);
      t = 8'($urandom); s = 8'($urandom); d = 1'($urandom); l = 1'($urandom);
      run(k, t, d, s, l, model_rx(l, t, s), d, 0, 1'b0, 8'($urandom));
    end
    run(2, 8'hC3, DEST_C, 8'h96, 1'b0, 8'h96, DEST_C, 20, 1'b0, 8'h11);
    run(1, 8'h18, DEST_B, 8'hB2, 1'b0, 8'hB2, DEST_B, 0, 1'b1, 8'h81);
    run(1, 8'h81, DEST_C, 8'h00, 1'b1, 8'h81, DEST_C, 0, 1'b0, 8'h00);
    st[1] = 1'b1; tx[1] = 8'h33; de[1] = 1'b1; sb[1] = 8'hE7; lb[1] = 1'b0;
    @(posedge clk); #1;
    st[1] = 1'b0;
    n = 0; rises = 0; ps = 0;
    while (rises < 4 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (sc[1] && !ps) rises++;
      ps = sc[1];
    end
    chk("reach_bit4", rises, 4);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {cs[1], sc[1], bz[1], dn[1]}, 4'b1000);
    quiet = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (dn[1] !== 1'b0 || bz[1] !== 1'b0) quiet = 0;
    end
    @(negedge clk) rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dn[1] !== 1'b0) quiet = 0;
    end
    chk("rst_no_done", quiet, 1);
    chk("rst_rx", {rx[1], ds[1]}, 9'h000);
    run(1, 8'h5A, DEST_C, 8'h00, 1'b1, 8'h5A, DEST_C, 0, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
